fifo_uart_tx: RTL and testbench

- Consumer for the team's synchronous_fifo. It pops 8-bit bytes from the FIFO read side (out/empty/read_en) and serialises each one as an asynchronous UART frame on `tx`.
- Frame format: start bit, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
- It sits between the FIFO and the chip-level serial pin, so it is the reader that matches the FIFO's writer side.

---
 rtl/fifo_uart_tx.sv | 129 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises them as UART frames (start, 8 data LSB-first, opt. even parity, 1-2 stop).
// Latency: pop pulse 1 cycle after IDLE qualifies, start bit 2 cycles after the pop; frame = (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT.
// Backpressure: never pops while fifo_empty; enable/fifo_empty are only sampled in IDLE, so an in-flight frame always completes.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    shift, shift_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic          par, par_n;
    logic          baud_last;
    logic          tx_n, busy_n, rd_n, done_n;

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        baud_n    = baud + BW'(1);
        bit_n     = bit_cnt;
        par_n     = par;
        baud_last = (baud == BAUD_MAX);

        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (enable && !fifo_empty) state_n = FETCH;
            end
            FETCH: begin
                baud_n  = '0;
                state_n = LOAD;
            end
            LOAD: begin
                baud_n  = '0;
                shift_n = fifo_data;
                par_n   = ^fifo_data;
                state_n = START;
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_MAX) state_n = IDLE;
                    else                     bit_n   = bit_cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so each registered output lines up with its state.
        rd_n   = (state_n == FETCH);
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (baud_n == BAUD_MAX) && (bit_n == STOP_MAX);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= '0;
            baud         <= '0;
            bit_cnt      <= '0;
            par          <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            fifo_read_en <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            shift        <= shift_n;
            baud         <= baud_n;
            bit_cnt      <= bit_n;
            par          <= par_n;
            tx           <= tx_n;
            busy         <= busy_n;
            fifo_read_en <= rd_n;
            frame_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2, 4 clocks per bit) fed by behavioural FIFOs,
// frames checked cycle by cycle against bit patterns built from the byte scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       en0     = 1'b0;
    logic       en1     = 1'b0;
    logic       empty0  = 1'b1;
    logic       empty1  = 1'b1;
    logic [7:0] data0   = '0;
    logic [7:0] data1   = '0;
    logic       wr0     = 1'b0;
    logic       wr1     = 1'b0;
    logic [7:0] wr_dat0 = '0;
    logic [7:0] wr_dat1 = '0;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

    logic [7:0] q0[$], q1[$], exp0[$], exp1[$];
    int  rd_cnt0 = 0, rd_cnt1 = 0;
    bit  uf0 = 1'b0, uf1 = 1'b0;
    int  cyc = 0;
    int  vectors = 0, miscompares = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(en0), .fifo_empty(empty0), .fifo_data(data0),
        .fifo_read_en(rd0), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
        .clk(clk), .reset(reset), .enable(en1), .fifo_empty(empty1), .fifo_data(data1),
        .fifo_read_en(rd1), .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous FIFO models: registered read data, write visible to empty one edge later.
    always @(posedge clk) begin
        if (rd0) begin
            if (q0.size() == 0) uf0 <= 1'b1;
            else begin
                data0   <= q0.pop_front();
                rd_cnt0 <= rd_cnt0 + 1;
            end
        end
        if (wr0) q0.push_back(wr_dat0);
        empty0 <= (q0.size() == 0);
    end

    always @(posedge clk) begin
        if (rd1) begin
            if (q1.size() == 0) uf1 <= 1'b1;
            else begin
                data1   <= q1.pop_front();
                rd_cnt1 <= rd_cnt1 + 1;
            end
        end
        if (wr1) q1.push_back(wr_dat1);
        empty1 <= (q1.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        chk(tag, 32'(observed), 32'(expected));
    endtask

    // {tx, busy, frame_done, fifo_read_en}
    function automatic logic [3:0] obs(input bit sel);
        return sel ? {tx1, busy1, done1, rd1} : {tx0, busy0, done0, rd0};
    endfunction

    function automatic logic [11:0] frame_bits(input logic [7:0] b, input bit par_en);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par_en) f[9] = ^b;
        return f;
    endfunction

    task automatic push(input bit sel, input logic [7:0] b);
        if (sel) begin
            wr1 = 1'b1; wr_dat1 = b; exp1.push_back(b);
        end else begin
            wr0 = 1'b1; wr_dat0 = b; exp0.push_back(b);
        end
        @(negedge clk);
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic wait_read(input bit sel, output int n);
        logic [3:0] o;
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            o    = obs(sel);
            seen = o[0];
        end
        chk("read_seen", 32'(seen), 32'd1);
    endtask

    // Called at the FETCH-cycle negedge; walks LOAD, the whole frame and the following IDLE cycle.
    task automatic check_frame(input bit sel, input int drop_at);
        logic [7:0]  b;
        logic [11:0] f;
        int nb;
        if (sel && exp1.size() > 0)       b = exp1.pop_front();
        else if (!sel && exp0.size() > 0) b = exp0.pop_front();
        else                              b = 8'h00;
        f  = frame_bits(b, sel);
        nb = sel ? 12 : 10;
        chk4("fetch", obs(sel), 4'b1101);
        @(negedge clk);
        chk4("load", obs(sel), 4'b1100);
        for (int i = 0; i < nb * CPB; i++) begin
            @(negedge clk);
            if (i == drop_at) en0 = 1'b0;
            chk4($sformatf("frame b=%02h i=%0d", b, i), obs(sel),
                 {f[i / CPB], 1'b1, (i == nb * CPB - 1), 1'b0});
        end
        @(negedge clk);
        chk4("idle_after", obs(sel), 4'b1000);
    endtask

    initial begin
        int n, c0;
        logic [3:0] o;

        #1 reset = 1'b0;
        en0 = 1'b1;
        @(negedge clk);
        push(1'b0, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk4("reset_dut", obs(1'b0), 4'b1000);
            chk4("reset_dut_p", obs(1'b1), 4'b1000);
        end
        reset = 1'b1;
        wait_read(1'b0, n);
        chk("release_latency", n, 1);
        check_frame(1'b0, -1);

        en0 = 1'b0;
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        en0 = 1'b1;
        wait_read(1'b0, n);
        c0 = cyc;
        check_frame(1'b0, -1);
        wait_read(1'b0, n);
        chk("b2b_spacing", cyc - c0, 43);
        check_frame(1'b0, -1);
        repeat (60) @(negedge clk);
        chk("reads_after_b2b", rd_cnt0, 3);

        push(1'b1, 8'h07);
        en1 = 1'b1;
        wait_read(1'b1, n);
        check_frame(1'b1, -1);
        en1 = 1'b0;
        repeat (2) push(1'b1, 8'($urandom_range(0, 255)));
        en1 = 1'b1;
        repeat (2) begin
            wait_read(1'b1, n);
            check_frame(1'b1, -1);
        end
        en1 = 1'b0;

        en0 = 1'b0;
        repeat (3) push(1'b0, 8'($urandom_range(0, 255)));
        repeat (100) @(negedge clk);
        chk("no_read_disabled", rd_cnt0, 3);
        en0 = 1'b1;
        wait_read(1'b0, n);
        check_frame(1'b0, 20);
        repeat (60) @(negedge clk);
        chk("one_read_after_drop", rd_cnt0, 4);
        en0 = 1'b1;
        repeat (2) begin
            wait_read(1'b0, n);
            check_frame(1'b0, -1);
        end

        en0 = 1'b0;
        repeat (6) push(1'b0, 8'($urandom_range(0, 255)));
        en0 = 1'b1;
        repeat (6) begin
            wait_read(1'b0, n);
            check_frame(1'b0, -1);
        end

        en0 = 1'b0;
        push(1'b0, 8'($urandom_range(0, 255)));
        push(1'b0, 8'($urandom_range(0, 255)));
        en0 = 1'b1;
        wait_read(1'b0, n);
        repeat (19) @(negedge clk);
        o = obs(1'b0);
        chk("data_bit3", 32'(o[3]), 32'(exp0[0][3]));
        reset = 1'b0;
        #1;
        chk4("reset_mid_frame", obs(1'b0), 4'b1000);
        void'(exp0.pop_front());
        repeat (3) begin
            @(negedge clk);
            chk4("reset_hold", obs(1'b0), 4'b1000);
        end
        reset = 1'b1;
        wait_read(1'b0, n);
        chk("restart_latency", n, 1);
        check_frame(1'b0, -1);

        repeat (20) @(negedge clk);
        chk("reads_total", rd_cnt0, 14);
        chk("reads_total_p", rd_cnt1, 3);
        chk("underflow", 32'({uf1, uf0}), 32'd0);
        chk("scoreboard_drained", exp0.size() + exp1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
